screen_fill_writer: RTL and testbench

Write-side front end for the screen frame buffer RAM. Merges two sources into the single write port (write_address/data/load) that the frame buffer consumes: CPU memory-mapped screen writes, and a hardware fill engine that writes one 16-pixel value to every screen word (clear to white/black or pattern). CPU writes always win; the fill engine stalls around them. Outputs are registered and drive the frame buffer's write port directly.

---
 rtl/screen_fill_writer.sv | 84 ++++++++
 tb/tb_screen_fill_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/screen_fill_writer.sv
// Write-port arbiter for the screen frame buffer: merges CPU screen writes with a
// full-screen fill engine. CPU writes always win, and the fill stalls for a cycle on each one.
module screen_fill_writer #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_load,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] data_out,
    output logic              load
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // The comparison is against the last address rather than a wrapped count,
    // so WORDS == 2**ADDR_W completes without the counter ever overflowing.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] counter;
    logic [DATA_W-1:0] fill_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            fill_word     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            write_address <= '0;
            data_out      <= '0;
            load          <= 1'b0;
        end else begin
            done <= 1'b0;
            load <= 1'b0;
            if (cpu_load) begin
                load          <= 1'b1;
                write_address <= cpu_address;
                data_out      <= cpu_data;
            end
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        fill_word <= fill_value;
                        counter   <= '0;
                        busy      <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (!cpu_load) begin
                        load          <= 1'b1;
                        write_address <= counter;
                        data_out      <= fill_word;
                        if (counter == LAST_ADDR) begin
                            state <= FINISH;
                        end else begin
                            counter <= counter + ADDR_W'(1);
                        end
                    end
                end
                // One extra cycle after the last fill word so done lines up with busy falling.
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_fill_writer.sv
// Bench for screen_fill_writer: a small instance (8 words) is checked against a queue-based
// reference model and a vector table; a full-size instance is checked for a full 8192-word sweep.
module tb_screen_fill_writer;

    localparam int SIM_WORDS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] cpuAddr = '0;
    logic [15:0] cpuData = '0;
    logic        cpuLoad = 1'b0;
    logic        fillStart = 1'b0;
    logic [15:0] fillValue = '0;

    logic        busy8, done8, load8;
    logic [12:0] addr8;
    logic [15:0] data8;
    logic        busyBig, doneBig, loadBig;
    logic [12:0] addrBig;
    logic [15:0] dataBig;

    int vectorsApplied = 0;
    int miscompares = 0;

    screen_fill_writer #(.ADDR_W(13), .DATA_W(16), .WORDS(SIM_WORDS)) dut8 (
        .clk(clk), .reset(reset), .cpu_address(cpuAddr), .cpu_data(cpuData),
        .cpu_load(cpuLoad), .fill_start(fillStart), .fill_value(fillValue),
        .busy(busy8), .done(done8), .write_address(addr8), .data_out(data8), .load(load8)
    );

    screen_fill_writer #(.ADDR_W(13), .DATA_W(16), .WORDS(8192)) dutBig (
        .clk(clk), .reset(reset), .cpu_address(cpuAddr), .cpu_data(cpuData),
        .cpu_load(cpuLoad), .fill_start(fillStart), .fill_value(fillValue),
        .busy(busyBig), .done(doneBig), .write_address(addrBig), .data_out(dataBig), .load(loadBig)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted fill enqueues every address; idle write slots drain the queue.
    logic [12:0] fillQ[$];
    logic        mBusy, mDone, mLoad;
    logic [12:0] mAddr;
    logic [15:0] mData, mValue;

    task automatic modelReset();
        fillQ.delete();
        mBusy = 0; mDone = 0; mLoad = 0; mAddr = '0; mData = '0; mValue = '0;
    endtask

    task automatic modelStep();
        bit started;
        started = 0;
        mDone = 0;
        if (mBusy && fillQ.size() == 0) begin
            mBusy = 0;
            mDone = 1;
        end else if (!mBusy && fillStart) begin
            mBusy = 1;
            started = 1;
            mValue = fillValue;
            for (int a = 0; a < SIM_WORDS; a++) fillQ.push_back(13'(a));
        end
        if (cpuLoad) begin
            mLoad = 1; mAddr = cpuAddr; mData = cpuData;
        end else if (mBusy && !started) begin
            mLoad = 1; mAddr = fillQ.pop_front(); mData = mValue;
        end else begin
            mLoad = 0;
        end
    endtask

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectorsApplied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // Packs {load, busy, done, address, data}; address/data only matter when load is high.
    function automatic logic [31:0] pack(input logic l, input logic b, input logic d,
                                         input logic [12:0] a, input logic [15:0] v);
        return {l, b, d, l ? a : 13'd0, l ? v : 16'd0};
    endfunction

    task automatic checkOutput(input string name);
        compare(name, pack(load8, busy8, done8, addr8, data8), pack(mLoad, mBusy, mDone, mAddr, mData));
    endtask

    task automatic checkReset(input string name);
        compare(name, {load8, busy8, done8, addr8, data8}, 32'd0);
    endtask

    task automatic applyStimulus(input logic cl, input logic [12:0] ca, input logic [15:0] cd,
                                 input logic fs, input logic [15:0] fv, input string name);
        cpuLoad = cl; cpuAddr = ca; cpuData = cd; fillStart = fs; fillValue = fv;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput(name);
    endtask

    task automatic idleCycle(input string name);
        applyStimulus(1'b0, 13'h0, 16'h0, 1'b0, 16'h0, name);
    endtask

    // Runs idle cycles until done, counting busy cycles seen on the way.
    task automatic runToDone(input string name, input int busyBefore, input int expBusy);
        int busyCount;
        bit seen;
        busyCount = busyBefore;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            idleCycle(name);
            if (done8) seen = 1;
            else if (busy8) busyCount++;
        end
        compare({name, "_busyCycles"}, 32'(busyCount), 32'(expBusy));
        compare({name, "_doneSeen"}, {31'd0, seen}, 32'd1);
    endtask

    typedef struct {
        logic        cpuLoad;
        logic [12:0] cpuAddr;
        logic [15:0] cpuData;
        logic        fillStart;
        logic [15:0] fillValue;
        logic        expLoad;
        logic [12:0] expAddr;
        logic [15:0] expData;
        logic        expBusy;
        logic        expDone;
    } tableRowT;

    tableRowT rows[13];

    function automatic tableRowT mkRow(input logic cl, input logic [12:0] ca, input logic [15:0] cd,
                                       input logic fs, input logic [15:0] fv, input logic el,
                                       input logic [12:0] ea, input logic [15:0] ed,
                                       input logic eb, input logic edn);
        tableRowT r;
        r.cpuLoad = cl; r.cpuAddr = ca; r.cpuData = cd; r.fillStart = fs; r.fillValue = fv;
        r.expLoad = el; r.expAddr = ea; r.expData = ed; r.expBusy = eb; r.expDone = edn;
        return r;
    endfunction

    initial begin
        int seqErr, loads, doneCycle, nextAddr;
        logic [12:0] lastAddr;

        // CPU write/idle, then a fill started alongside a CPU write, with a re-pulse ignored.
        rows[0]  = mkRow(1, 13'h0123, 16'hBEEF, 0, 16'h0000, 1, 13'h0123, 16'hBEEF, 0, 0);
        rows[1]  = mkRow(0, 13'h0000, 16'h0000, 0, 16'h0000, 0, 13'h0000, 16'h0000, 0, 0);
        rows[2]  = mkRow(1, 13'h0200, 16'h1234, 1, 16'hA5A5, 1, 13'h0200, 16'h1234, 1, 0);
        rows[3]  = mkRow(0, 13'h0000, 16'h0000, 0, 16'h0000, 1, 13'h0000, 16'hA5A5, 1, 0);
        rows[4]  = mkRow(0, 13'h0000, 16'h0000, 1, 16'h0F0F, 1, 13'h0001, 16'hA5A5, 1, 0);
        for (int i = 5; i < 11; i++)
            rows[i] = mkRow(0, 13'h0, 16'h0, 0, 16'h0, 1, 13'(i - 3), 16'hA5A5, 1, 0);
        rows[11] = mkRow(0, 13'h0000, 16'h0000, 0, 16'h0000, 0, 13'h0000, 16'h0000, 0, 1);
        rows[12] = mkRow(0, 13'h0000, 16'h0000, 0, 16'h0000, 0, 13'h0000, 16'h0000, 0, 0);

        modelReset();
        repeat (2) @(negedge clk);
        checkReset("resetInit");
        reset = 0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(rows[i].cpuLoad, rows[i].cpuAddr, rows[i].cpuData,
                          rows[i].fillStart, rows[i].fillValue, $sformatf("model_row%0d", i));
            compare($sformatf("table_row%0d", i), pack(load8, busy8, done8, addr8, data8),
                    pack(rows[i].expLoad, rows[i].expBusy, rows[i].expDone, rows[i].expAddr, rows[i].expData));
        end

        applyStimulus(0, 13'h0, 16'h0, 1, 16'hFFFF, "plainStart");
        runToDone("plainFill", 1, 9);
        idleCycle("plainAfterDone");

        applyStimulus(0, 13'h0, 16'h0, 1, 16'hC3C3, "preemptStart");
        for (int i = 0; i < 3; i++) idleCycle("preemptFill");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 13'h1000, 16'h00AA, 0, 16'h0, "preemptCpu");
            compare("preemptCpuWrite", pack(load8, busy8, done8, addr8, data8),
                    pack(1'b1, 1'b1, 1'b0, 13'h1000, 16'h00AA));
        end
        idleCycle("preemptResume");
        compare("preemptResumeAddr3", pack(load8, busy8, done8, addr8, data8),
                pack(1'b1, 1'b1, 1'b0, 13'd3, 16'hC3C3));
        runToDone("preemptFill", 7, 11);

        applyStimulus(0, 13'h0, 16'h0, 1, 16'h3333, "midStart");
        for (int i = 0; i < 5; i++) idleCycle("midFill");
        #1 reset = 1;
        #1 checkReset("midFillReset");
        modelReset();
        @(negedge clk);
        reset = 0;
        idleCycle("afterResetNoDone");
        applyStimulus(0, 13'h0, 16'h0, 1, 16'h5555, "restartStart");
        idleCycle("restartFirst");
        compare("restartAddr0", pack(load8, busy8, done8, addr8, data8),
                pack(1'b1, 1'b1, 1'b0, 13'd0, 16'h5555));
        runToDone("restartFill", 2, 9);

        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(3) == 0), 13'($urandom), 16'($urandom),
                          ($urandom_range(9) == 0), 16'($urandom), "random");

        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        modelReset();
        applyStimulus(0, 13'h0, 16'h0, 1, 16'h0F0F, "bigStart");
        compare("bigBusyAfterStart", {31'd0, busyBig}, 32'd1);
        seqErr = 0; loads = 0; doneCycle = -1; nextAddr = 0; lastAddr = '0;
        for (int c = 1; c <= 9000 && doneCycle < 0; c++) begin
            idleCycle("bigSmallSide");
            if (loadBig) begin
                if (int'(addrBig) != nextAddr || dataBig != 16'h0F0F) seqErr++;
                nextAddr++;
                loads++;
                lastAddr = addrBig;
            end
            if (doneBig) doneCycle = c;
        end
        compare("bigSequenceErrors", 32'(seqErr), 32'd0);
        compare("bigLoadCount", 32'(loads), 32'd8192);
        compare("bigLastAddr", {19'd0, lastAddr}, 32'h1FFF);
        compare("bigDoneCycle", 32'(doneCycle), 32'd8193);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
